// File: rtl/prbs7_checker.sv
// Receive-side PRBS-7 (x^7 + x^6 + 1) checker: self-synchronising hunt, then lock to a local LFSR.
// Define PRBS7_CHECKER_BITCOUNT_EN to count mismatching bits instead of errored words.
module prbs7_checker #(
    parameter int W           = 16,
    parameter int LOCK_COUNT  = 8,
    parameter int LOSS_THRESH = 4,
    parameter int CNT_W       = 16,
    parameter int STRETCH     = 4000000
) (
    input  logic             clk160,
    input  logic             reset,
    input  logic [W-1:0]     rx_data,
    input  logic             rx_valid,
    input  logic             clear_counts,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic             led_err
);

    localparam int PC_W  = $clog2(W + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam int TMR_W = $clog2(STRETCH + 1);
    localparam int RUN_W = 8;
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Rolls the last 7 reference bits forward W bits; bit W-1 is the earliest predicted bit.
    function automatic logic [W-1:0] predict(input logic [6:0] ref_bits);
        logic [6:0]   h;
        logic         nb;
        logic [W-1:0] w;
        h = ref_bits;
        w = '0;
        for (int i = W - 1; i >= 0; i--) begin
            nb   = h[6] ^ h[5];
            w[i] = nb;
            h    = {h[5:0], nb};
        end
        return w;
    endfunction

`ifdef PRBS7_CHECKER_BITCOUNT_EN
    function automatic logic [PC_W-1:0] popcount(input logic [W-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < W; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction
`endif

    logic [W-1:0]     s1_data_q, s1_data_d;
    logic             s1_valid_q, s1_valid_d;
    state_t           state_q, state_d;
    logic [6:0]       lfsr_q, lfsr_d;
    logic [RUN_W-1:0] clean_run_q, clean_run_d;
    logic [RUN_W-1:0] err_run_q, err_run_d;
    logic             hit_q, hit_d;
`ifdef PRBS7_CHECKER_BITCOUNT_EN
    logic [PC_W-1:0]  bits_q, bits_d;
`endif
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             led_q, led_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;

    logic [W-1:0]     expected;
    logic [W-1:0]     mism;
    logic             word_ok;
    logic [SUM_W-1:0] inc;
    logic [SUM_W-1:0] sum;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        s1_data_d   = rx_data;
        s1_valid_d  = rx_valid;
        expected    = predict(lfsr_q);
        mism        = s1_data_q ^ expected;
        word_ok     = (mism == '0);
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        clean_run_d = clean_run_q;
        err_run_d   = err_run_q;
        hit_d       = 1'b0;

        if (s1_valid_q) begin
            case (state_q)
                HUNT: begin
                    // The previous received word is the reference while hunting.
                    lfsr_d    = s1_data_q[6:0];
                    err_run_d = '0;
                    if (word_ok && (s1_data_q != '0)) begin
                        if (clean_run_q == RUN_W'(LOCK_COUNT - 1)) begin
                            state_d     = LOCKED;
                            clean_run_d = '0;
                        end else begin
                            clean_run_d = clean_run_q + RUN_W'(1);
                        end
                    end else begin
                        clean_run_d = '0;
                    end
                end
                LOCKED: begin
                    lfsr_d = expected[6:0];
                    if (!word_ok) begin
                        hit_d = 1'b1;
                        if (err_run_q == RUN_W'(LOSS_THRESH - 1)) begin
                            state_d     = HUNT;
                            err_run_d   = '0;
                            clean_run_d = '0;
                            lfsr_d      = s1_data_q[6:0];
                        end else begin
                            err_run_d = err_run_q + RUN_W'(1);
                        end
                    end else begin
                        err_run_d = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

`ifdef PRBS7_CHECKER_BITCOUNT_EN
        bits_d = hit_d ? popcount(mism) : '0;
        inc    = SUM_W'(bits_q);
`else
        inc    = SUM_W'(1);
`endif
        sum = SUM_W'(err_cnt_q) + inc;

        locked_d    = (state_q == LOCKED);
        err_pulse_d = hit_q;
        err_cnt_d   = err_cnt_q;
        led_d       = led_q;
        tmr_d       = tmr_q;
        if (tmr_q != '0) begin
            tmr_d = tmr_q - TMR_W'(1);
        end else begin
            led_d = 1'b0;
        end
        if (hit_q) begin
            err_cnt_d = (sum > CNT_MAX) ? CNT_W'(CNT_MAX) : sum[CNT_W-1:0];
            led_d     = 1'b1;
            tmr_d     = TMR_W'(STRETCH - 1);
        end
        // A clear on the same edge as an errored result drops that increment and LED set.
        if (clear_counts) begin
            err_cnt_d = '0;
            led_d     = 1'b0;
            tmr_d     = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous and overrides all inputs.
    always_ff @(posedge clk160) begin
        if (reset) begin
            s1_data_q   <= '0;
            s1_valid_q  <= 1'b0;
            state_q     <= HUNT;
            lfsr_q      <= '0;
            clean_run_q <= '0;
            err_run_q   <= '0;
            hit_q       <= 1'b0;
`ifdef PRBS7_CHECKER_BITCOUNT_EN
            bits_q      <= '0;
`endif
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            led_q       <= 1'b0;
            tmr_q       <= '0;
        end else begin
            s1_data_q   <= s1_data_d;
            s1_valid_q  <= s1_valid_d;
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            clean_run_q <= clean_run_d;
            err_run_q   <= err_run_d;
            hit_q       <= hit_d;
`ifdef PRBS7_CHECKER_BITCOUNT_EN
            bits_q      <= bits_d;
`endif
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            led_q       <= led_d;
            tmr_q       <= tmr_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign led_err   = led_q;

endmodule

// File: tb/tb_prbs7_checker.sv
// Directed bench for prbs7_checker: lock timing, single/multi-bit errors, loss/relock, saturation, clear, reset.
// Expectations for the 3-bit error case follow PRBS7_CHECKER_BITCOUNT_EN.
module tb_prbs7_checker;

    localparam int W           = 16;
    localparam int LOCK_COUNT  = 8;
    localparam int LOSS_THRESH = 4;
    localparam int CNT_W       = 4;
    localparam int STRETCH     = 20;
`ifdef PRBS7_CHECKER_BITCOUNT_EN
    localparam int EXP3 = 3;
`else
    localparam int EXP3 = 1;
`endif

    logic             clk160 = 1'b0;
    logic             reset;
    logic [W-1:0]     rx_data;
    logic             rx_valid;
    logic             clear_counts;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_cnt;
    logic             led_err;

    int         checks = 0;
    int         errors = 0;
    int         pulses = 0;
    int         p0;
    logic [6:0] g;
    logic [W-1:0] w;

    always #5 clk160 = ~clk160;

    prbs7_checker #(
        .W(W), .LOCK_COUNT(LOCK_COUNT), .LOSS_THRESH(LOSS_THRESH),
        .CNT_W(CNT_W), .STRETCH(STRETCH)
    ) dut (
        .clk160(clk160), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .clear_counts(clear_counts), .locked(locked), .err_pulse(err_pulse),
        .err_cnt(err_cnt), .led_err(led_err)
    );

    always @(posedge clk160) begin
        #1;
        if (err_pulse === 1'b1) pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Transmit-side generator: b[n] = b[n-7] ^ b[n-6], earliest bit in the MSB.
    task automatic next_word(output logic [W-1:0] wd);
        logic nb;
        wd = '0;
        for (int i = W - 1; i >= 0; i--) begin
            nb    = g[6] ^ g[5];
            wd[i] = nb;
            g     = {g[5:0], nb};
        end
    endtask

    // Drive one cycle of inputs; returns at the following falling edge.
    task automatic step(input logic [W-1:0] d, input logic v, input logic clr, input logic rst);
        rx_data      = d;
        rx_valid     = v;
        clear_counts = clr;
        reset        = rst;
        @(posedge clk160);
        @(negedge clk160);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) step('0, 1'b0, 1'b0, 1'b1);
        check("rst_locked", 32'(locked), 0);
        check("rst_pulse", 32'(err_pulse), 0);
        check("rst_cnt", 32'(err_cnt), 0);
        check("rst_led", 32'(led_err), 0);

        // Clean stream with idle bubbles after lock.
        g = 7'h7F;
        for (int i = 0; i < 220; i++) begin
            if (i >= 40 && (i % 9) == 0) begin
                step(16'hA5C3, 1'b0, 1'b0, 1'b0);
            end else begin
                next_word(w);
                step(w, 1'b1, 1'b0, 1'b0);
            end
            if (i == 9)  check("lock_early", 32'(locked), 0);
            if (i == 10) check("lock_edge", 32'(locked), 1);
        end
        check("clean_pulses", 32'(pulses), 0);
        check("clean_cnt", 32'(err_cnt), 0);
        check("clean_locked", 32'(locked), 1);

        // Single-bit error in word 50.
        p0 = pulses;
        for (int i = 0; i < 80; i++) begin
            next_word(w);
            if (i == 50) w = w ^ 16'h0008;
            step(w, 1'b1, 1'b0, 1'b0);
            if (i == 51) check("pulse_early", 32'(err_pulse), 0);
            if (i == 52) begin
                check("pulse_edge", 32'(err_pulse), 1);
                check("cnt_one", 32'(err_cnt), 1);
                check("lock_kept", 32'(locked), 1);
                check("led_set", 32'(led_err), 1);
            end
            if (i == 53) check("pulse_one_cycle", 32'(err_pulse), 0);
            if (i == 71) check("led_last", 32'(led_err), 1);
            if (i == 72) check("led_off", 32'(led_err), 0);
        end
        check("single_pulses", 32'(pulses - p0), 1);

        // Three bits flipped in one word.
        next_word(w);
        step(w, 1'b1, 1'b1, 1'b0);
        check("clear_cnt", 32'(err_cnt), 0);
        p0 = pulses;
        for (int i = 0; i < 10; i++) begin
            next_word(w);
            if (i == 2) w = w ^ 16'h4201;
            step(w, 1'b1, 1'b0, 1'b0);
        end
        check("multi_cnt", 32'(err_cnt), EXP3);
        check("multi_pulses", 32'(pulses - p0), 1);

        // Four consecutive errored words drop lock; then relock.
        next_word(w);
        step(w, 1'b1, 1'b1, 1'b0);
        p0 = pulses;
        for (int i = 0; i < 30; i++) begin
            next_word(w);
            if (i >= 2 && i <= 5) w = w ^ 16'h0001;
            step(w, 1'b1, 1'b0, 1'b0);
            if (i == 6) check("loss_hold", 32'(locked), 1);
            if (i == 7) begin
                check("loss_edge", 32'(locked), 0);
                check("loss_cnt", 32'(err_cnt), 4);
            end
            if (i == 15) check("relock_early", 32'(locked), 0);
            if (i == 16) check("relock_edge", 32'(locked), 1);
        end
        check("loss_pulses", 32'(pulses - p0), 4);
        check("loss_cnt_kept", 32'(err_cnt), 4);

        // All-zero input never locks; a real stream then locks.
        for (int i = 0; i < 2; i++) step('0, 1'b0, 1'b0, 1'b1);
        p0 = pulses;
        for (int i = 0; i < 100; i++) step('0, 1'b1, 1'b0, 1'b0);
        check("zero_locked", 32'(locked), 0);
        check("zero_cnt", 32'(err_cnt), 0);
        check("zero_pulses", 32'(pulses - p0), 0);
        g = 7'h7F;
        for (int i = 0; i < 12; i++) begin
            next_word(w);
            step(w, 1'b1, 1'b0, 1'b0);
            if (i == 9)  check("zlock_early", 32'(locked), 0);
            if (i == 10) check("zlock_edge", 32'(locked), 1);
        end

        // Twenty isolated single-bit errors saturate a 4-bit counter.
        p0 = pulses;
        for (int i = 0; i < 60; i++) begin
            next_word(w);
            if ((i % 3) == 0) w = w ^ (W'(1) << (i % W));
            step(w, 1'b1, 1'b0, 1'b0);
            if (i == 2)  check("sat_first", 32'(err_cnt), 1);
            if (i == 41) check("sat_14", 32'(err_cnt), 14);
            if (i == 44) check("sat_15", 32'(err_cnt), 15);
        end
        check("sat_hold", 32'(err_cnt), 15);
        check("sat_pulses", 32'(pulses - p0), 20);
        check("sat_locked", 32'(locked), 1);

        // Clear on the same edge as an errored result.
        for (int i = 0; i < 6; i++) begin
            next_word(w);
            if (i == 0) w = w ^ 16'h0100;
            step(w, 1'b1, (i == 2), 1'b0);
            if (i == 2) begin
                check("clr_cnt", 32'(err_cnt), 0);
                check("clr_pulse", 32'(err_pulse), 1);
                check("clr_led", 32'(led_err), 0);
            end
            if (i == 3) check("clr_led_stays", 32'(led_err), 0);
        end
        check("clr_locked", 32'(locked), 1);

        // Reset mid-stream clears everything; checker reacquires.
        for (int i = 0; i < 3; i++) begin
            next_word(w);
            if (i == 0) w = w ^ 16'h0020;
            step(w, 1'b1, 1'b0, 1'b0);
        end
        check("pre_rst_cnt", 32'(err_cnt), 1);
        check("pre_rst_led", 32'(led_err), 1);
        next_word(w);
        step(w, 1'b1, 1'b0, 1'b1);
        check("mid_rst_locked", 32'(locked), 0);
        check("mid_rst_pulse", 32'(err_pulse), 0);
        check("mid_rst_cnt", 32'(err_cnt), 0);
        check("mid_rst_led", 32'(led_err), 0);
        for (int i = 0; i < 12; i++) begin
            next_word(w);
            step(w, 1'b1, 1'b0, 1'b0);
            if (i == 9)  check("rlock_early", 32'(locked), 0);
            if (i == 10) check("rlock_edge", 32'(locked), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prbs7_checker.md
Name: prbs7_checker

Overview:
- Receive-side PRBS-7 checker (x^7 + x^6 + 1) for one GTX lane of the PRBS LED link test.
- Sits after the GTX RX user-data output and checks the stream produced by the transmit-side generator.
- Acquires lock with a self-synchronising search, then compares against a local free-running LFSR.
- Reports lock, error events, a saturating error count and a stretched error LED; the LED feeds the led_fp status bits read back by the VIO.

Parameters:
- W, 16: RX data width per clock. Legal range 8..32.
- LOCK_COUNT, 8: consecutive clean words needed in HUNT before lock. Legal range 1..255.
- LOSS_THRESH, 4: consecutive errored words in LOCKED that cause loss of lock. Legal range 1..255.
- CNT_W, 16: error counter width.
- STRETCH, 4000000: cycles led_err stays high after the last error.

Ports:
- clk160, input, 1: RX user clock. Everything is in this domain.
- reset, input, 1: synchronous, active-high.
- rx_data, input, W: received word. Bit W-1 is earliest in time, bit 0 is latest.
- rx_valid, input, 1: rx_data qualifier. A word is accepted on a rising edge where rx_valid=1.
- clear_counts, input, 1: synchronous clear of err_cnt and led_err.
- locked, output, 1: checker is in the LOCKED state.
- err_pulse, output, 1: one-cycle strobe per errored word.
- err_cnt, output, CNT_W: saturating error count.
- led_err, output, 1: stretched error indicator.

Behaviour:
- Reset: every output is 0, the FSM goes to HUNT, all counters are 0, and the local LFSR is 0. Reset wins over every other input.
- Sequence rule: b[n] = b[n-7] XOR b[n-6].
- Prediction: the expected word is computed from the last 7 bits of the previous reference, rolled W bits forward.
- Pipeline, 2 stages:
  - Stage 1 registers rx_data and rx_valid.
  - Stage 2 compares, updates the FSM and counters, and drives err_pulse.
  - Result: a word accepted at edge k updates outputs at edge k+2.
- Cycles with rx_valid=0 do not advance the LFSR, the FSM or any counter.
- HUNT state:
  - Reference is the previous received word (self-synchronising).
  - A word is clean when it equals the prediction and is not all-zero. An all-zero word always counts as a mismatch, which rejects LFSR lockup.
  - Clean word: clean_run increments. Mismatch: clean_run returns to 0.
  - When clean_run reaches LOCK_COUNT: load the local LFSR from the low 7 bits of the current word, go to LOCKED, and set locked=1 on the same edge.
  - In HUNT, err_pulse stays 0 and err_cnt does not change.
- LOCKED state:
  - Reference is the local LFSR, which advances W bits per accepted word.
  - Any bit mismatch makes the word errored: err_pulse=1 for one cycle, err_run increments, and err_cnt is updated.
  - A clean word returns err_run to 0.
  - When err_run reaches LOSS_THRESH: go to HUNT, set locked=0 and clean_run=0. err_cnt keeps its value.
- err_cnt:
  - Increment is per the Optional Feature.
  - Saturates at 2^CNT_W - 1 and never wraps. An increment that would overflow yields the maximum.
- led_err:
  - Set on err_pulse and held for STRETCH cycles after the last err_pulse. A new error restarts the stretch timer.
- clear_counts:
  - Sets err_cnt and led_err to 0 and clears the stretch timer.
  - If clear_counts coincides with an errored word, the clear wins: that word's increment and its led_err set are discarded, but err_pulse still fires.
  - clear_counts does not affect locked or the FSM.
- Reset mid-stream: the checker must reacquire from HUNT with no stale LFSR state.

Optional Feature:
- Macro: PRBS7_CHECKER_BITCOUNT_EN.
- Defined: err_cnt increments by the popcount of the mismatching bits in the word (0..W), saturating.
- Undefined: err_cnt increments by 1 per errored word, and no popcount logic is synthesised.

Test Plan:
- Clean PRBS-7 stream, seed 7'h7F, rx_valid=1 continuously, 200 words -> locked=1 at edge LOCK_COUNT+2 (10), then err_cnt=0 and err_pulse never asserted.
- After lock, flip bit 3 of word 50 -> exactly one err_pulse, 2 cycles after that word; err_cnt=1; locked stays 1; led_err high for STRETCH cycles (sim with STRETCH=20).
- After lock, flip 3 bits in one word -> err_cnt=3 with PRBS7_CHECKER_BITCOUNT_EN, err_cnt=1 without it; one err_pulse in both cases.
- All-zero rx_data for 100 words from reset -> locked stays 0 and err_cnt=0. Then switch to a valid stream -> locks after LOCK_COUNT clean words.
- After lock, 4 consecutive corrupted words with LOSS_THRESH=4 -> locked=0 on the 4th result and err_cnt=4 (word mode). Clean stream resumes -> relock.
- CNT_W=4, 20 isolated single-bit errors -> err_cnt saturates at 15. clear_counts on the same cycle as an error -> err_cnt=0 and err_pulse=1. Reset mid-stream -> all outputs 0 next cycle.
